axi_dw_rd_lane_scheduler: RTL and testbench
===========================================

Name: axi_dw_rd_lane_scheduler

Overview:
- Read-lane allocator/scheduler for the AXI data-width upsizer read path.
- Each accepted AR gets one of NumLanes read lanes (lane buffers live in the converter datapath).
- Each returning R beat is steered to the lane owning the oldest outstanding transaction with that ID; the lane is freed on the last beat.
- Same-ID ordering is kept with an age matrix, so the converter may keep several same-ID reads in flight.

Parameters:
- NumLanes, 4, number of read lanes (= AXI_MAX_READS of the converter); ≥1.
- IdWidth, 4, AXI ID width.
- LaneIdxWidth, $clog2(NumLanes) (1 if NumLanes==1), derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- alloc_valid_i  in  1  AR wants a lane.
- alloc_ready_o  out  1  free lane available.
- alloc_id_i  in  IdWidth  AR ID.
- alloc_lane_o  out  LaneIdxWidth  lane granted (valid with alloc_valid_i & alloc_ready_o).
- r_valid_i  in  1  R beat present on master side.
- r_ready_i  in  1  R beat consumed by datapath.
- r_id_i  in  IdWidth  R beat ID.
- r_last_i  in  1  R beat is last of burst.
- r_hit_o  out  1  a busy lane matches r_id_i.
- r_lane_o  out  LaneIdxWidth  lane owning the beat (0 when !r_hit_o).
- lane_busy_o  out  NumLanes  per-lane busy vector.
- free_cnt_o  out  LaneIdxWidth+1  number of free lanes.
- err_o  out  1  sticky: beat handshaked with no matching lane.

Behaviour:
- Per-lane state: busy bit, stored ID, older row (NumLanes bits; older[k][j]=1 ⇒ lane j allocated before lane k and still busy).
- Reset (async): all busy=0, IDs=0, older matrix=0, err_o=0. Outputs after reset: alloc_ready_o=1, alloc_lane_o=0, r_hit_o=0, r_lane_o=0, lane_busy_o=0, free_cnt_o=NumLanes. Reset mid-operation discards all lanes; no beat is steered after reset.
- Allocation, combinational from registered state:
  - alloc_ready_o = |~busy.
  - alloc_lane_o = lowest-index free lane; 0 when none free.
  - alloc_ready_o does not depend on alloc_valid_i.
- Allocation handshake (alloc_valid_i & alloc_ready_o) at clock edge, lane k:
  - busy[k]=1, id[k]=alloc_id_i.
  - older[k] = current busy vector, excluding any lane being freed this cycle.
- Steering, combinational:
  - candidate[j] = busy[j] & id[j]==r_id_i & ~|(older[j] & match), where match = busy & id==r_id_i.
  - Exactly one candidate exists when any lane matches.
  - r_hit_o = r_valid_i & |match; r_lane_o = index of the candidate.
- Free: on r_valid_i & r_ready_i & r_last_i & r_hit_o, lane r_lane_o gets busy=0 at the edge, and its column is cleared in every older row.
- Non-last beats change no state.
- Simultaneous alloc and free in one cycle:
  - Both take effect.
  - The freed lane is not offered to the allocation in the same cycle; it is allocatable from the next cycle.
  - The newly allocated lane does not record the freed lane as older.
- Full: alloc_ready_o=0 until a last beat frees a lane. No combinational path r_* → alloc_ready_o.
- Empty, or unmatched ID:
  - r_hit_o=0.
  - If r_valid_i & r_ready_i anyway, err_o sets and holds until reset; state is unchanged.
- free_cnt_o = popcount(~busy), registered state.
- Latency: grant is 0-cycle (same cycle as request); steering is 0-cycle; busy/free updates are visible the cycle after the handshake.
- Invariant for the assertions: no lane k has older[k][k]=1, and older[k][j]=1 implies busy[j].

Test Plan:
- Reset, then idle → alloc_ready_o=1, free_cnt_o=4, lane_busy_o=4'b0000, err_o=0.
- Allocate IDs 3,5,7,9 on consecutive cycles → lanes 0,1,2,3 granted; lane_busy_o=4'b1111; alloc_ready_o=0.
- Allocate ID 2 twice (lanes 0,1); send a 4-beat burst with r_id_i=2 → all beats r_lane_o=0; lane 0 freed after last beat. Next ID-2 burst → r_lane_o=1.
- Full (4 lanes busy); in one cycle, last beat for lane 2 plus alloc_valid_i → no grant that cycle. Next cycle → alloc_lane_o=2, free_cnt_o=1.
- R beat handshaked with r_id_i=15, no lane holding ID 15 → r_hit_o=0, err_o=1 persists; lane_busy_o unchanged.
- 3 lanes busy, assert rst_ni low mid-burst → lane_busy_o=0 and free_cnt_o=4 immediately (async); subsequent allocation grants lane 0.

Source files
------------

// File: rtl/axi_dw_rd_lane_scheduler.sv
// ---------------------------------------------------------------------------
// axi_dw_rd_lane_scheduler
//   Read-lane allocator/scheduler for the AXI data-width upsizer read path.
//   Every accepted AR is given one of NumLanes lanes. Every returning R beat
//   is steered to the lane that holds the oldest outstanding read with the
//   beat's ID. A lane is released on the last beat of its burst. An age
//   matrix keeps same-ID reads in order, so several can be in flight at once.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   alloc_valid_i     AR requests a lane
//   alloc_ready_o     at least one lane is free (registered state only)
//   alloc_id_i        AR ID stored with the granted lane
//   alloc_lane_o      lowest free lane (0 when none are free)
//   r_valid_i         R beat present
//   r_ready_i         R beat consumed by the datapath
//   r_id_i            R beat ID
//   r_last_i          R beat is the last one of its burst
//   r_hit_o           a busy lane matches r_id_i (qualified by r_valid_i)
//   r_lane_o          lane owning the beat (0 when !r_hit_o)
//   lane_busy_o       per-lane busy vector
//   free_cnt_o        number of free lanes
//   err_o             sticky: a beat was handshaked with no matching lane
// ---------------------------------------------------------------------------
module axi_dw_rd_lane_scheduler #(
  parameter  int unsigned NumLanes     = 4,
  parameter  int unsigned IdWidth      = 4,
  localparam int unsigned LaneIdxWidth = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    alloc_valid_i,
  output logic                    alloc_ready_o,
  input  logic [IdWidth-1:0]      alloc_id_i,
  output logic [LaneIdxWidth-1:0] alloc_lane_o,
  input  logic                    r_valid_i,
  input  logic                    r_ready_i,
  input  logic [IdWidth-1:0]      r_id_i,
  input  logic                    r_last_i,
  output logic                    r_hit_o,
  output logic [LaneIdxWidth-1:0] r_lane_o,
  output logic [NumLanes-1:0]     lane_busy_o,
  output logic [LaneIdxWidth:0]   free_cnt_o,
  output logic                    err_o
);

  localparam int unsigned CntWidth = LaneIdxWidth + 1;

  logic [NumLanes-1:0] busy_q, busy_d;
  logic [IdWidth-1:0]  id_q    [NumLanes];
  logic [IdWidth-1:0]  id_d    [NumLanes];
  // older_q[k][j] = 1: lane j was allocated before lane k and is still busy.
  logic [NumLanes-1:0] older_q [NumLanes];
  logic [NumLanes-1:0] older_d [NumLanes];
  logic                err_q,  err_d;

  logic [NumLanes-1:0] match;
  logic [NumLanes-1:0] cand;
  logic [NumLanes-1:0] free_mask;
  logic                any_match;
  logic                alloc_fire;
  logic                free_fire;
  logic                err_fire;
  logic                found_r;
  logic                found_a;
  logic [CntWidth-1:0] free_cnt;

  // Steering: the candidate is the matching lane with no older matching lane.
  always_comb begin
    match = '0;
    cand  = '0;
    for (int unsigned j = 0; j < NumLanes; j++) begin
      match[j] = busy_q[j] && (id_q[j] == r_id_i);
    end
    for (int unsigned j = 0; j < NumLanes; j++) begin
      cand[j] = match[j] && !(|(older_q[j] & match));
    end
  end

  assign any_match = |match;
  assign r_hit_o   = r_valid_i && any_match;

  always_comb begin
    r_lane_o = '0;
    found_r  = 1'b0;
    for (int unsigned j = 0; j < NumLanes; j++) begin
      if (r_hit_o && cand[j] && !found_r) begin
        r_lane_o = LaneIdxWidth'(j);
        found_r  = 1'b1;
      end
    end
  end

  // Allocation looks only at registered busy state, so a lane freed this
  // cycle is not offered until the next one and r_* never reaches ready.
  always_comb begin
    alloc_lane_o = '0;
    found_a      = 1'b0;
    free_cnt     = '0;
    for (int unsigned j = 0; j < NumLanes; j++) begin
      if (!busy_q[j]) begin
        free_cnt = free_cnt + CntWidth'(1);
        if (!found_a) begin
          alloc_lane_o = LaneIdxWidth'(j);
          found_a      = 1'b1;
        end
      end
    end
  end

  assign alloc_ready_o = |(~busy_q);
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign free_fire     = r_valid_i && r_ready_i && r_last_i && r_hit_o;
  assign err_fire      = r_valid_i && r_ready_i && !r_hit_o;

  always_comb begin
    free_mask = '0;
    for (int unsigned j = 0; j < NumLanes; j++) begin
      if (free_fire && (r_lane_o == LaneIdxWidth'(j))) free_mask[j] = 1'b1;
    end
  end

  // Next state: free first (drop busy bit and its age column everywhere),
  // then allocate with an age row that excludes the lane freed this cycle.
  always_comb begin
    busy_d = busy_q & ~free_mask;
    err_d  = err_q || err_fire;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      id_d[k]    = id_q[k];
      older_d[k] = older_q[k] & ~free_mask;
    end
    if (alloc_fire) begin
      for (int unsigned k = 0; k < NumLanes; k++) begin
        if (alloc_lane_o == LaneIdxWidth'(k)) begin
          busy_d[k]  = 1'b1;
          id_d[k]    = alloc_id_i;
          older_d[k] = busy_q & ~free_mask;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int unsigned k = 0; k < NumLanes; k++) begin
        id_q[k]    <= '0;
        older_q[k] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
      for (int unsigned k = 0; k < NumLanes; k++) begin
        id_q[k]    <= id_d[k];
        older_q[k] <= older_d[k];
      end
    end
  end

  assign lane_busy_o = busy_q;
  assign free_cnt_o  = free_cnt;
  assign err_o       = err_q;

  for (genvar k = 0; k < NumLanes; k++) begin : g_age_inv
    a_no_self_age : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !older_q[k][k]);
    a_age_busy : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (older_q[k] & ~busy_q) == '0);
  end

  a_one_cand : assert property (@(posedge clk_i) disable iff (!rst_ni)
    any_match |-> $onehot(cand));

endmodule

// File: tb/tb_axi_dw_rd_lane_scheduler.sv
module tb_axi_dw_rd_lane_scheduler;

  localparam int N = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       alloc_valid_i;
  logic       alloc_ready_o;
  logic [3:0] alloc_id_i;
  logic [1:0] alloc_lane_o;
  logic       r_valid_i;
  logic       r_ready_i;
  logic [3:0] r_id_i;
  logic       r_last_i;
  logic       r_hit_o;
  logic [1:0] r_lane_o;
  logic [3:0] lane_busy_o;
  logic [2:0] free_cnt_o;
  logic       err_o;

  int n_checks = 0;
  int n_pass   = 0;

  axi_dw_rd_lane_scheduler #(.NumLanes(4), .IdWidth(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_id_i    (alloc_id_i),
    .alloc_lane_o  (alloc_lane_o),
    .r_valid_i     (r_valid_i),
    .r_ready_i     (r_ready_i),
    .r_id_i        (r_id_i),
    .r_last_i      (r_last_i),
    .r_hit_o       (r_hit_o),
    .r_lane_o      (r_lane_o),
    .lane_busy_o   (lane_busy_o),
    .free_cnt_o    (free_cnt_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: outstanding reads kept in allocation order.
  typedef struct {
    logic [3:0] id;
    int         lane;
  } ent_t;

  ent_t q[$];
  bit   m_err;

  function automatic bit lane_used(int l);
    foreach (q[i]) if (q[i].lane == l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    return q.size() < N;
  endfunction

  function automatic logic [1:0] m_alloc_lane();
    for (int l = 0; l < N; l++) if (!lane_used(l)) return 2'(l);
    return 2'd0;
  endfunction

  function automatic logic m_match(logic [3:0] id);
    foreach (q[i]) if (q[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_rlane(logic [3:0] id);
    foreach (q[i]) if (q[i].id == id) return 2'(q[i].lane);
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] b = '0;
    foreach (q[i]) b[q[i].lane] = 1'b1;
    return b;
  endfunction

  function automatic logic [2:0] m_free();
    return 3'(N - q.size());
  endfunction

  task automatic m_clock(bit av, logic [3:0] aid, bit rv, bit rr, logic [3:0] rid, bit rl);
    bit         rdy = m_ready();
    logic [1:0] al  = m_alloc_lane();
    bit         hit = rv && m_match(rid);
    if (rv && rr && !hit) m_err = 1'b1;
    if (rv && rr && rl && hit) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].id == rid) begin
          q.delete(i);
          break;
        end
      end
    end
    if (av && rdy) q.push_back('{id: aid, lane: int'(al)});
  endtask

  task automatic drive(bit av, logic [3:0] aid, bit rv, bit rr, logic [3:0] rid, bit rl);
    alloc_valid_i = av;
    alloc_id_i    = aid;
    r_valid_i     = rv;
    r_ready_i     = rr;
    r_id_i        = rid;
    r_last_i      = rl;
  endtask

  task automatic advance();
    bit         av  = alloc_valid_i;
    logic [3:0] aid = alloc_id_i;
    bit         rv  = r_valid_i;
    bit         rr  = r_ready_i;
    logic [3:0] rid = r_id_i;
    bit         rl  = r_last_i;
    @(posedge clk_i);
    m_clock(av, aid, rv, rr, rid, rl);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0);
    #1;
    n_checks++; if (alloc_ready_o !== 1'b1) $display("FAIL reset_ready got %b exp 1", alloc_ready_o); else n_pass++;
    n_checks++; if (free_cnt_o !== 3'd4) $display("FAIL reset_free_cnt got %0d exp 4", free_cnt_o); else n_pass++;
    n_checks++; if (lane_busy_o !== 4'b0000) $display("FAIL reset_busy got %b exp 0000", lane_busy_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", err_o); else n_pass++;
    n_checks++; if (alloc_lane_o !== 2'd0) $display("FAIL reset_alloc_lane got %0d exp 0", alloc_lane_o); else n_pass++;
    n_checks++; if (r_hit_o !== 1'b0 || r_lane_o !== 2'd0) $display("FAIL reset_steer got hit=%b lane=%0d exp 0/0", r_hit_o, r_lane_o); else n_pass++;
  endtask

  task automatic test_fill();
    logic [3:0] ids [4];
    ids[0] = 4'd3; ids[1] = 4'd5; ids[2] = 4'd7; ids[3] = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      drive(1, ids[i], 0, 0, 0, 0);
      #1;
      n_checks++; if (alloc_ready_o !== 1'b1 || alloc_lane_o !== 2'(i))
        $display("FAIL fill_grant%0d got rdy=%b lane=%0d exp 1/%0d", i, alloc_ready_o, alloc_lane_o, i); else n_pass++;
      advance();
    end
    @(negedge clk_i);
    drive(1, 4'd11, 0, 0, 0, 0);
    #1;
    n_checks++; if (lane_busy_o !== 4'b1111) $display("FAIL fill_busy got %b exp 1111", lane_busy_o); else n_pass++;
    n_checks++; if (alloc_ready_o !== 1'b0) $display("FAIL fill_full_ready got %b exp 0", alloc_ready_o); else n_pass++;
    n_checks++; if (free_cnt_o !== 3'd0) $display("FAIL fill_free_cnt got %0d exp 0", free_cnt_o); else n_pass++;
    advance();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      drive(0, 0, 1, 1, ids[i], 1);
      #1;
      n_checks++; if (r_hit_o !== 1'b1 || r_lane_o !== 2'(i))
        $display("FAIL fill_drain%0d got hit=%b lane=%0d exp 1/%0d", i, r_hit_o, r_lane_o, i); else n_pass++;
      advance();
    end
  endtask

  task automatic test_same_id();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      drive(1, 4'd2, 0, 0, 0, 0);
      advance();
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_i);
      drive(0, 0, 1, 1, 4'd2, b == 3);
      #1;
      n_checks++; if (r_hit_o !== 1'b1 || r_lane_o !== 2'd0)
        $display("FAIL same_id_beat%0d got hit=%b lane=%0d exp 1/0", b, r_hit_o, r_lane_o); else n_pass++;
      advance();
    end
    @(negedge clk_i);
    drive(0, 0, 1, 1, 4'd2, 1);
    #1;
    n_checks++; if (lane_busy_o !== 4'b0010) $display("FAIL same_id_busy got %b exp 0010", lane_busy_o); else n_pass++;
    n_checks++; if (r_lane_o !== 2'd1) $display("FAIL same_id_second got %0d exp 1", r_lane_o); else n_pass++;
    advance();
  endtask

  task automatic test_full_simul();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      drive(1, 4'(i), 0, 0, 0, 0);
      advance();
    end
    @(negedge clk_i);
    drive(1, 4'd6, 1, 1, 4'd3, 1);
    #1;
    n_checks++; if (alloc_ready_o !== 1'b0) $display("FAIL simul_no_grant got %b exp 0", alloc_ready_o); else n_pass++;
    n_checks++; if (r_lane_o !== 2'd2) $display("FAIL simul_free_lane got %0d exp 2", r_lane_o); else n_pass++;
    advance();
    @(negedge clk_i);
    drive(1, 4'd6, 0, 0, 0, 0);
    #1;
    n_checks++; if (alloc_ready_o !== 1'b1 || alloc_lane_o !== 2'd2)
      $display("FAIL simul_next_grant got rdy=%b lane=%0d exp 1/2", alloc_ready_o, alloc_lane_o); else n_pass++;
    n_checks++; if (free_cnt_o !== 3'd1) $display("FAIL simul_free_cnt got %0d exp 1", free_cnt_o); else n_pass++;
    advance();
    while (q.size() > 0) begin
      logic [3:0] id = q[0].id;
      @(negedge clk_i);
      drive(0, 0, 1, 1, id, 1);
      #1;
      n_checks++; if (r_lane_o !== m_rlane(id))
        $display("FAIL simul_drain got %0d exp %0d", r_lane_o, m_rlane(id)); else n_pass++;
      advance();
    end
  endtask

  task automatic test_unmatched();
    @(negedge clk_i);
    drive(1, 4'd4, 0, 0, 0, 0);
    advance();
    @(negedge clk_i);
    drive(0, 0, 1, 1, 4'd15, 1);
    #1;
    n_checks++; if (r_hit_o !== 1'b0) $display("FAIL unmatched_hit got %b exp 0", r_hit_o); else n_pass++;
    advance();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      n_checks++; if (err_o !== 1'b1) $display("FAIL unmatched_err%0d got %b exp 1", i, err_o); else n_pass++;
      n_checks++; if (lane_busy_o !== 4'b0001) $display("FAIL unmatched_busy got %b exp 0001", lane_busy_o); else n_pass++;
      advance();
    end
    @(negedge clk_i);
    drive(0, 0, 1, 1, 4'd4, 1);
    advance();
  endtask

  task automatic test_async_reset();
    logic [3:0] ids [3];
    ids[0] = 4'd1; ids[1] = 4'd1; ids[2] = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive(1, ids[i], 0, 0, 0, 0);
      advance();
    end
    @(negedge clk_i);
    drive(0, 0, 1, 1, 4'd1, 0);
    advance();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    n_checks++; if (lane_busy_o !== 4'b0000) $display("FAIL arst_busy got %b exp 0000", lane_busy_o); else n_pass++;
    n_checks++; if (free_cnt_o !== 3'd4) $display("FAIL arst_free_cnt got %0d exp 4", free_cnt_o); else n_pass++;
    n_checks++; if (r_hit_o !== 1'b0) $display("FAIL arst_hit got %b exp 0", r_hit_o); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("FAIL arst_err got %b exp 0", err_o); else n_pass++;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(negedge clk_i);
    drive(1, 4'd7, 0, 0, 0, 0);
    #1;
    n_checks++; if (alloc_lane_o !== 2'd0 || alloc_ready_o !== 1'b1)
      $display("FAIL arst_regrant got rdy=%b lane=%0d exp 1/0", alloc_ready_o, alloc_lane_o); else n_pass++;
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bit         av  = ($urandom_range(0, 9) < 5);
      logic [3:0] aid = 4'($urandom_range(0, 3));
      bit         rv  = ($urandom_range(0, 9) < 7);
      bit         rr  = ($urandom_range(0, 9) < 8);
      bit         rl  = ($urandom_range(0, 1) == 1);
      logic [3:0] rid;
      if (q.size() > 0 && $urandom_range(0, 19) < 19) rid = q[$urandom_range(0, q.size() - 1)].id;
      else rid = 4'($urandom_range(0, 15));
      @(negedge clk_i);
      drive(av, aid, rv, rr, rid, rl);
      #1;
      n_checks++; if (alloc_ready_o !== m_ready())
        $display("FAIL rnd_ready c=%0d got %b exp %b", c, alloc_ready_o, m_ready()); else n_pass++;
      n_checks++; if (alloc_lane_o !== m_alloc_lane())
        $display("FAIL rnd_alloc_lane c=%0d got %0d exp %0d", c, alloc_lane_o, m_alloc_lane()); else n_pass++;
      n_checks++; if (r_hit_o !== (rv && m_match(rid)))
        $display("FAIL rnd_hit c=%0d got %b exp %b", c, r_hit_o, rv && m_match(rid)); else n_pass++;
      n_checks++; if (r_lane_o !== ((rv && m_match(rid)) ? m_rlane(rid) : 2'd0))
        $display("FAIL rnd_rlane c=%0d got %0d exp %0d", c, r_lane_o, (rv && m_match(rid)) ? m_rlane(rid) : 2'd0); else n_pass++;
      n_checks++; if (lane_busy_o !== m_busy())
        $display("FAIL rnd_busy c=%0d got %b exp %b", c, lane_busy_o, m_busy()); else n_pass++;
      n_checks++; if (free_cnt_o !== m_free())
        $display("FAIL rnd_free_cnt c=%0d got %0d exp %0d", c, free_cnt_o, m_free()); else n_pass++;
      n_checks++; if (err_o !== m_err)
        $display("FAIL rnd_err c=%0d got %b exp %b", c, err_o, m_err); else n_pass++;
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_err  = 1'b0;
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #22 rst_ni = 1'b1;
    test_reset();
    test_fill();
    test_same_id();
    test_full_simul();
    test_unmatched();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
